// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 31-lane TDM demultiplexer.
// Optional parity checking is enabled by defining DEMUX_PARITY_EN.
package tdm_demux_pkg;

    localparam int LANES = 31;
    localparam int SEL_W = 5;

    typedef logic [SEL_W-1:0] lane_idx_t;
    typedef logic [LANES-1:0] lane_mask_t;

    localparam lane_idx_t INVALID_SEL = 5'd31;
    localparam lane_idx_t LAST_LANE   = 5'd30;

endpackage

// File: rtl/tdm_demux_if.sv
// Receive-side symbol bus for tdm_demux; in_par exists only when DEMUX_PARITY_EN is defined.
interface tdm_demux_if #(
    parameter int WIDTH = 2
);
    import tdm_demux_pkg::*;

    logic             in_valid;
    lane_idx_t        in_sel;
    logic [WIDTH-1:0] in_data;
`ifdef DEMUX_PARITY_EN
    logic             in_par;
`endif
    logic             seq_mode;
    logic             in_sync;

`ifdef DEMUX_PARITY_EN
    modport master (output in_valid, in_sel, in_data, in_par, seq_mode, in_sync);
    modport slave  (input  in_valid, in_sel, in_data, in_par, seq_mode, in_sync);
`else
    modport master (output in_valid, in_sel, in_data, seq_mode, in_sync);
    modport slave  (input  in_valid, in_sel, in_data, seq_mode, in_sync);
`endif

endinterface

// File: rtl/tdm_demux_slot_ctr.sv
// Wrapping slot counter (0..30) for sequential-mode lane selection.
module tdm_demux_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      sync,
    input  logic      inc,
    output lane_idx_t slot
);

    lane_idx_t slot_q;
    lane_idx_t slot_d;
    lane_idx_t base;

    // Sync clears first so a same-cycle increment starts from slot 0.
    always_comb begin
        base   = sync ? '0 : slot_q;
        slot_d = base;
        if (inc) begin
            slot_d = (base == LAST_LANE) ? '0 : base + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// 31-lane time-division demultiplexer with refresh tracking and frame-complete pulse.
// Define DEMUX_PARITY_EN to drop writes whose {in_data, in_par} has odd parity.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    tdm_demux_if.slave       bus,
    output logic [WIDTH-1:0] out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
    output logic [WIDTH-1:0] out8,  out9,  out10, out11, out12, out13, out14, out15,
    output logic [WIDTH-1:0] out16, out17, out18, out19, out20, out21, out22, out23,
    output logic [WIDTH-1:0] out24, out25, out26, out27, out28, out29, out30,
    output lane_mask_t       upd,
    output logic             frame_done,
    output logic             err,
    output lane_idx_t        slot
);

    logic [WIDTH-1:0] lane_q [LANES];
    logic [WIDTH-1:0] lane_d [LANES];
    lane_mask_t       mask_q, mask_d;
    lane_mask_t       upd_q, upd_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    lane_idx_t        slot_cnt;
    lane_idx_t        cur_slot;
    lane_idx_t        lane;
    logic             lane_ok;
    logic             par_ok;
    logic             accept;

    // In sequential mode every valid cycle consumes a slot, even if parity drops it.
    tdm_demux_slot_ctr u_slot_ctr (
        .clk  (clk),
        .rst  (rst),
        .sync (bus.in_sync),
        .inc  (bus.in_valid && bus.seq_mode),
        .slot (slot_cnt)
    );

    always_comb begin
        cur_slot = bus.in_sync ? '0 : slot_cnt;
        lane     = bus.seq_mode ? cur_slot : bus.in_sel;
        lane_ok  = (lane != INVALID_SEL);
`ifdef DEMUX_PARITY_EN
        par_ok   = ~^{bus.in_data, bus.in_par};
`else
        par_ok   = 1'b1;
`endif
        accept   = bus.in_valid && lane_ok && par_ok;

        lane_d       = lane_q;
        upd_d        = '0;
        mask_d       = bus.in_sync ? '0 : mask_q;
        frame_done_d = 1'b0;
        err_d        = bus.in_valid && !(lane_ok && par_ok);

        // Completing the mask fires frame_done and restarts tracking in the same update.
        if (accept) begin
            lane_d[lane] = bus.in_data;
            upd_d        = lane_mask_t'(1) << lane;
            mask_d       = mask_d | upd_d;
            if (mask_d == '1) begin
                frame_done_d = 1'b1;
                mask_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
            mask_q       <= '0;
            upd_q        <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            mask_q       <= mask_d;
            upd_q        <= upd_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign upd        = upd_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign slot       = slot_cnt;

    assign out0  = lane_q[0];
    assign out1  = lane_q[1];
    assign out2  = lane_q[2];
    assign out3  = lane_q[3];
    assign out4  = lane_q[4];
    assign out5  = lane_q[5];
    assign out6  = lane_q[6];
    assign out7  = lane_q[7];
    assign out8  = lane_q[8];
    assign out9  = lane_q[9];
    assign out10 = lane_q[10];
    assign out11 = lane_q[11];
    assign out12 = lane_q[12];
    assign out13 = lane_q[13];
    assign out14 = lane_q[14];
    assign out15 = lane_q[15];
    assign out16 = lane_q[16];
    assign out17 = lane_q[17];
    assign out18 = lane_q[18];
    assign out19 = lane_q[19];
    assign out20 = lane_q[20];
    assign out21 = lane_q[21];
    assign out22 = lane_q[22];
    assign out23 = lane_q[23];
    assign out24 = lane_q[24];
    assign out25 = lane_q[25];
    assign out26 = lane_q[26];
    assign out27 = lane_q[27];
    assign out28 = lane_q[28];
    assign out29 = lane_q[29];
    assign out30 = lane_q[30];

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (honours DEMUX_PARITY_EN when defined).
module tb_tdm_demux;
    import tdm_demux_pkg::*;

    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] out_w [LANES];
    lane_mask_t       upd;
    logic             frame_done;
    logic             err;
    lane_idx_t        slot;

    logic [WIDTH-1:0] exp_lane [LANES];
    int               errors = 0;
    int               checks = 0;

    tdm_demux_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .out0(out_w[0]),   .out1(out_w[1]),   .out2(out_w[2]),   .out3(out_w[3]),
        .out4(out_w[4]),   .out5(out_w[5]),   .out6(out_w[6]),   .out7(out_w[7]),
        .out8(out_w[8]),   .out9(out_w[9]),   .out10(out_w[10]), .out11(out_w[11]),
        .out12(out_w[12]), .out13(out_w[13]), .out14(out_w[14]), .out15(out_w[15]),
        .out16(out_w[16]), .out17(out_w[17]), .out18(out_w[18]), .out19(out_w[19]),
        .out20(out_w[20]), .out21(out_w[21]), .out22(out_w[22]), .out23(out_w[23]),
        .out24(out_w[24]), .out25(out_w[25]), .out26(out_w[26]), .out27(out_w[27]),
        .out28(out_w[28]), .out29(out_w[29]), .out30(out_w[30]),
        .upd(upd), .frame_done(frame_done), .err(err), .slot(slot)
    );

    always #5 clk = ~clk;

    // Applies one cycle of stimulus and returns 1ns after the sampling edge.
    task automatic drive(input logic v, input logic [4:0] sel, input logic [1:0] d,
                         input logic bad_par, input logic seq, input logic sy);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = d;
`ifdef DEMUX_PARITY_EN
        bus.in_par   = (^d) ^ bad_par;
`endif
        bus.seq_mode = seq;
        bus.in_sync  = sy;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            exp_lane[k] = '0;
            checks++;
            if (out_w[k] !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_out%0d: got %0d expected 0", k, out_w[k]);
            end
        end
        checks++;
        if ({upd, frame_done, err, slot} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_flags: upd=%h fd=%b err=%b slot=%0d expected all 0",
                     upd, frame_done, err, slot);
        end
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({upd, frame_done, err, slot} !== '0) begin
                errors++;
                $display("[TB] FAIL idle_cycle%0d: upd=%h fd=%b err=%b slot=%0d expected all 0",
                         c, upd, frame_done, err, slot);
            end
        end
    endtask

    task automatic test_addressed();
        drive(1, 12, 2'b10, 0, 0, 0);
        exp_lane[12] = 2'd2;
        checks++;
        if (out_w[12] !== 2'd2 || upd !== (lane_mask_t'(1) << 12)) begin
            errors++;
            $display("[TB] FAIL addr_lane12: out12=%0d upd=%h expected 2 and bit 12", out_w[12], upd);
        end
        drive(1, 13, 2'b11, 0, 0, 0);
        exp_lane[13] = 2'd3;
        checks++;
        if (out_w[13] !== 2'd3 || upd !== (lane_mask_t'(1) << 13) || out_w[12] !== 2'd2) begin
            errors++;
            $display("[TB] FAIL addr_lane13: out13=%0d out12=%0d upd=%h expected 3, 2, bit 13",
                     out_w[13], out_w[12], upd);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (upd !== '0 || slot !== 5'd0) begin
            errors++;
            $display("[TB] FAIL addr_idle: upd=%h slot=%0d expected 0 and 0", upd, slot);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (out_w[k] !== exp_lane[k]) begin
                errors++;
                $display("[TB] FAIL addr_hold_out%0d: got %0d expected %0d", k, out_w[k], exp_lane[k]);
            end
        end
    endtask

    task automatic test_invalid_sel();
        drive(1, 31, 2'b01, 0, 0, 0);
        checks++;
        if (err !== 1'b1 || upd !== '0 || slot !== 5'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_sel: err=%b upd=%h slot=%0d fd=%b expected 1, 0, 0, 0",
                     err, upd, slot, frame_done);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (out_w[k] !== exp_lane[k]) begin
                errors++;
                $display("[TB] FAIL invalid_hold_out%0d: got %0d expected %0d", k, out_w[k], exp_lane[k]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_err_pulse: err=%b expected 0", err);
        end
    endtask

    task automatic test_sequential_frame();
        for (int k = 0; k < LANES; k++) begin
            drive(1, 0, 2'(k % 4), 0, 1, 0);
            exp_lane[k] = 2'(k % 4);
            checks++;
            if (upd !== (lane_mask_t'(1) << k) || frame_done !== (k == 30) || err !== 1'b0 ||
                slot !== 5'((k == 30) ? 0 : k + 1)) begin
                errors++;
                $display("[TB] FAIL seq_write%0d: upd=%h fd=%b err=%b slot=%0d", k, upd, frame_done, err, slot);
            end
        end
        drive(0, 0, 0, 0, 1, 0);
        checks++;
        if (frame_done !== 1'b0 || slot !== 5'd0) begin
            errors++;
            $display("[TB] FAIL seq_after: fd=%b slot=%0d expected 0 and 0", frame_done, slot);
        end
        for (int k = 0; k < LANES; k++) begin
            checks++;
            if (out_w[k] !== exp_lane[k]) begin
                errors++;
                $display("[TB] FAIL seq_out%0d: got %0d expected %0d", k, out_w[k], exp_lane[k]);
            end
        end
    endtask

    task automatic test_resync();
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 2'd0, 0, 1, 0);
            exp_lane[k] = 2'd0;
        end
        checks++;
        if (slot !== 5'd10) begin
            errors++;
            $display("[TB] FAIL resync_pre_slot: got %0d expected 10", slot);
        end
        drive(1, 0, 2'b11, 0, 1, 1);
        exp_lane[0] = 2'd3;
        checks++;
        if (out_w[0] !== 2'd3 || slot !== 5'd1 || upd !== lane_mask_t'(1) || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL resync_write: out0=%0d slot=%0d upd=%h fd=%b expected 3, 1, bit 0, 0",
                     out_w[0], slot, upd, frame_done);
        end
        for (int k = 1; k < LANES; k++) begin
            drive(1, 0, 2'd1, 0, 1, 0);
            exp_lane[k] = 2'd1;
            checks++;
            if (frame_done !== (k == 30) || upd !== (lane_mask_t'(1) << k)) begin
                errors++;
                $display("[TB] FAIL resync_fill%0d: fd=%b upd=%h expected fd=%b", k, frame_done, upd, k == 30);
            end
        end
        checks++;
        if (slot !== 5'd0 || out_w[0] !== 2'd3 || out_w[30] !== 2'd1) begin
            errors++;
            $display("[TB] FAIL resync_end: slot=%0d out0=%0d out30=%0d expected 0, 3, 1",
                     slot, out_w[0], out_w[30]);
        end
    endtask

    task automatic test_mode_switch();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 2'd2, 0, 1, 0);
            exp_lane[k] = 2'd2;
        end
        drive(1, 20, 2'd3, 0, 0, 0);
        exp_lane[20] = 2'd3;
        checks++;
        if (slot !== 5'd3 || upd !== (lane_mask_t'(1) << 20) || out_w[20] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL mode_addr: slot=%0d upd=%h out20=%0d expected 3, bit 20, 3",
                     slot, upd, out_w[20]);
        end
        drive(1, 0, 2'd0, 0, 1, 0);
        exp_lane[3] = 2'd0;
        checks++;
        if (slot !== 5'd4 || upd !== (lane_mask_t'(1) << 3) || out_w[3] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mode_seq: slot=%0d upd=%h out3=%0d expected 4, bit 3, 0", slot, upd, out_w[3]);
        end
    endtask

    task automatic test_parity();
`ifdef DEMUX_PARITY_EN
        drive(1, 0, 2'b01, 1, 1, 0);
        checks++;
        if (err !== 1'b1 || upd !== '0 || slot !== 5'd5 || out_w[4] !== exp_lane[4]) begin
            errors++;
            $display("[TB] FAIL parity_bad: err=%b upd=%h slot=%0d out4=%0d expected 1, 0, 5, %0d",
                     err, upd, slot, out_w[4], exp_lane[4]);
        end
        drive(1, 0, 2'b01, 0, 1, 0);
        exp_lane[5] = 2'd1;
        checks++;
        if (err !== 1'b0 || upd !== (lane_mask_t'(1) << 5) || slot !== 5'd6 || out_w[5] !== 2'd1) begin
            errors++;
            $display("[TB] FAIL parity_good: err=%b upd=%h slot=%0d out5=%0d expected 0, bit 5, 6, 1",
                     err, upd, slot, out_w[5]);
        end
`else
        drive(1, 0, 2'b01, 1, 1, 0);
        exp_lane[4] = 2'd1;
        checks++;
        if (err !== 1'b0 || upd !== (lane_mask_t'(1) << 4) || slot !== 5'd5 || out_w[4] !== 2'd1) begin
            errors++;
            $display("[TB] FAIL noparity_write: err=%b upd=%h slot=%0d out4=%0d expected 0, bit 4, 5, 1",
                     err, upd, slot, out_w[4]);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        drive(1, 0, 2'd2, 0, 1, 1);
        for (int k = 1; k < 30; k++) begin
            drive(1, 0, 2'd2, 0, 1, 0);
        end
        rst = 1'b1;
        drive(1, 30, 2'd3, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            exp_lane[k] = '0;
            checks++;
            if (out_w[k] !== 2'd0) begin
                errors++;
                $display("[TB] FAIL midreset_out%0d: got %0d expected 0", k, out_w[k]);
            end
        end
        checks++;
        if ({upd, frame_done, err, slot} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: upd=%h fd=%b err=%b slot=%0d expected all 0",
                     upd, frame_done, err, slot);
        end
        drive(1, 30, 2'd3, 0, 0, 0);
        checks++;
        if (frame_done !== 1'b0 || upd !== (lane_mask_t'(1) << 30) || out_w[30] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL midreset_mask: fd=%b upd=%h out30=%0d expected 0, bit 30, 3",
                     frame_done, upd, out_w[30]);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sel   = '0;
        bus.in_data  = '0;
`ifdef DEMUX_PARITY_EN
        bus.in_par   = 1'b0;
`endif
        bus.seq_mode = 1'b0;
        bus.in_sync  = 1'b0;
        rst          = 1'b1;

        test_reset();
        test_addressed();
        test_invalid_sel();
        test_sequential_frame();
        test_resync();
        test_mode_switch();
        test_parity();
        test_reset_midframe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
